// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sequencing a single-port block RAM with configurable read latency.
// Optional macro MEM_PORT_ARBITER_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_ce,
    output logic              mem_oce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    localparam int unsigned CntW = 3;

    typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;

    state_e            state_q, state_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              capture;
    logic              idle, any_req, pick1, grant;

    assign idle    = (state_q == StIdle);
    assign any_req = m0_req | m1_req;
    assign grant   = idle & any_req;

`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
    logic last_q;

    // On contention, port 1 wins only if port 0 was the last winner.
    assign pick1 = m1_req & (~m0_req | ~last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (grant) begin
            last_q <= pick1;
        end
    end
`else
    assign pick1 = m1_req & ~m0_req;
`endif

    // Gated by rst_n so no grant is shown while reset is asserted.
    assign m0_gnt = rst_n & idle & m0_req & ~pick1;
    assign m1_gnt = rst_n & idle & pick1;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        capture = 1'b0;
        mem_ce  = 1'b0;
        mem_oce = 1'b0;
        mem_wre = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StAccess;
                    win_d   = pick1;
                    we_d    = pick1 ? m1_we    : m0_we;
                    addr_d  = pick1 ? m1_addr  : m0_addr;
                    wdata_d = pick1 ? m1_wdata : m0_wdata;
                end
            end
            StAccess: begin
                mem_ce  = 1'b1;
                mem_wre = we_q;
                mem_oce = ~we_q;
                if (we_q) begin
                    state_d = StIdle;
                    ack0_d  = ~win_q;
                    ack1_d  = win_q;
                end else begin
                    state_d = StWait;
                    cnt_d   = CntW'(RD_LAT);
                end
            end
            StWait: begin
                mem_oce = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    capture = 1'b1;
                    ack0_d  = ~win_q;
                    ack1_d  = win_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            win_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            if (capture && !win_q) rdata0_q <= mem_dout;
            if (capture && win_q)  rdata1_q <= mem_dout;
        end
    end

    assign m0_ack   = ack0_q;
    assign m1_ack   = ack1_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;
    assign mem_ad   = addr_q;
    assign mem_din  = wdata_q;
    assign busy     = ~idle;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (RD_LAT 1, 2, 4) with RAM models and an ack scoreboard.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NI = 3;

    typedef struct {
        int unsigned    cyc;
        logic [DW-1:0]  data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] m0_req, m0_we, m1_req, m1_we, m0_gnt, m1_gnt, m0_ack, m1_ack;
    logic [NI-1:0] mem_ce, mem_oce, mem_wre, busy;
    logic [AW-1:0] m0_addr [NI];
    logic [AW-1:0] m1_addr [NI];
    logic [AW-1:0] mem_ad [NI];
    logic [DW-1:0] m0_wdata [NI];
    logic [DW-1:0] m1_wdata [NI];
    logic [DW-1:0] m0_rdata [NI];
    logic [DW-1:0] m1_rdata [NI];
    logic [DW-1:0] mem_din [NI];
    logic [DW-1:0] mem_dout [NI];

    exp_t          exp_q [2*NI][$];
    logic [DW-1:0] last_rd [2*NI];
    int unsigned   oce_cnt [NI];
    int unsigned   cyc = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam int L = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
        logic [DW-1:0] ram [1<<AW];
        logic [DW-1:0] stg [L];

        initial for (int a = 0; a < (1 << AW); a++) ram[a] = 32'hC0DE_0000 | 32'(a);

        // Address sampled on ce; each further stage advances on oce.
        always @(posedge clk) begin
            if (mem_ce[k] && mem_wre[k]) ram[mem_ad[k]] <= mem_din[k];
            if (mem_ce[k] && !mem_wre[k]) stg[0] <= ram[mem_ad[k]];
            for (int i = 1; i < L; i++) if (mem_oce[k]) stg[i] <= stg[i-1];
        end
        assign mem_dout[k] = stg[L-1];

        mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .m0_req(m0_req[k]), .m0_we(m0_we[k]), .m0_addr(m0_addr[k]), .m0_wdata(m0_wdata[k]),
            .m0_gnt(m0_gnt[k]), .m0_ack(m0_ack[k]), .m0_rdata(m0_rdata[k]),
            .m1_req(m1_req[k]), .m1_we(m1_we[k]), .m1_addr(m1_addr[k]), .m1_wdata(m1_wdata[k]),
            .m1_gnt(m1_gnt[k]), .m1_ack(m1_ack[k]), .m1_rdata(m1_rdata[k]),
            .mem_ce(mem_ce[k]), .mem_oce(mem_oce[k]), .mem_wre(mem_wre[k]),
            .mem_ad(mem_ad[k]), .mem_din(mem_din[k]), .mem_dout(mem_dout[k]), .busy(busy[k])
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every ack and checks control invariants.
    always @(negedge clk) begin
        logic          a;
        logic [DW-1:0] d;
        int            idx;
        if (rst_n) begin
            for (int k = 0; k < NI; k++) begin
                for (int p = 0; p < 2; p++) begin
                    idx = k * 2 + p;
                    a   = (p == 1) ? m1_ack[k] : m0_ack[k];
                    d   = (p == 1) ? m1_rdata[k] : m0_rdata[k];
                    if (a) begin
                        if (exp_q[idx].size() == 0) begin
                            chk($sformatf("unexpected_ack_i%0d_p%0d", k, p), 1, 0);
                        end else begin
                            exp_t e;
                            e = exp_q[idx].pop_front();
                            chk($sformatf("ack_cycle_i%0d_p%0d", k, p), 64'(cyc), 64'(e.cyc));
                            chk($sformatf("ack_rdata_i%0d_p%0d", k, p), 64'(d), 64'(e.data));
                        end
                    end
                end
                chk($sformatf("ctl_outside_busy_i%0d", k),
                    64'((mem_ce[k] | mem_oce[k] | mem_wre[k]) & ~busy[k]), 0);
                chk($sformatf("wre_without_ce_i%0d", k), 64'(mem_wre[k] & ~mem_ce[k]), 0);
                chk($sformatf("gnt_both_i%0d", k), 64'(m0_gnt[k] & m1_gnt[k]), 0);
                if (mem_oce[k]) oce_cnt[k] = oce_cnt[k] + 1;
            end
        end
    end

    task automatic drive(int k, int p, bit r, bit we, logic [AW-1:0] a, logic [DW-1:0] d);
        if (p == 0) begin
            m0_req[k] = r; m0_we[k] = we; m0_addr[k] = a; m0_wdata[k] = d;
        end else begin
            m1_req[k] = r; m1_we[k] = we; m1_addr[k] = a; m1_wdata[k] = d;
        end
    endtask

    // Called just after a rising edge; returns just after the rising edge two cycles past the grant.
    task automatic issue(input int k, input int p, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] exp_rd, input bit hold,
                         output int unsigned g);
        int unsigned t0;
        bit          got;
        int          idx;
        t0  = cyc;
        got = 0;
        idx = k * 2 + p;
        g   = 0;
        drive(k, p, 1'b1, we, a, d);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((p == 1) ? m1_gnt[k] : m0_gnt[k]) begin
                got = 1;
                g   = cyc;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!got) begin
            chk("gnt_timeout", 0, 1);
            drive(k, p, 1'b0, we, a, d);
            return;
        end
        chk("gnt_delay", 64'(g - t0), 0);
        if (we) begin
            exp_q[idx].push_back('{cyc: g + 2, data: last_rd[idx]});
        end else begin
            exp_q[idx].push_back('{cyc: g + 2 + lat_of(k), data: exp_rd});
            last_rd[idx] = exp_rd;
        end
        @(posedge clk);
        #1;
        if (!hold) drive(k, p, 1'b0, we, a, d);
        @(negedge clk);
        chk("access_ce", 64'(mem_ce[k]), 1);
        chk("access_ad", 64'(mem_ad[k]), 64'(a));
        chk("access_wre", 64'(mem_wre[k]), 64'(we));
        if (we) chk("access_din", 64'(mem_din[k]), 64'(d));
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        for (int i = 0; i < 2 * NI; i++) begin
            exp_q[i].delete();
            last_rd[i] = '0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        flush();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic settle(int n);
        repeat (n) @(posedge clk);
        #1;
        for (int i = 0; i < 2 * NI; i++) chk($sformatf("pending_q%0d", i), 64'(exp_q[i].size()), 0);
    endtask

    initial begin
        int unsigned g, g_prev, o0;
        int          n, wins;
        int          exp_win [4];
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
        exp_win = '{0, 1, 0, 1};
`else
        exp_win = '{0, 0, 0, 0};
`endif
        for (int k = 0; k < NI; k++) begin
            drive(k, 0, 1'b0, 1'b0, '0, '0);
            drive(k, 1, 1'b0, 1'b0, '0, '0);
            oce_cnt[k] = 0;
        end
        flush();

        // Reset values with both ports requesting
        drive(1, 0, 1'b1, 1'b0, 10'h005, '0);
        drive(1, 1, 1'b1, 1'b0, 10'h005, '0);
        repeat (2) @(negedge clk);
        chk("rst_ctl", 64'({m0_gnt[1], m1_gnt[1], m0_ack[1], m1_ack[1],
                            mem_ce[1], mem_oce[1], mem_wre[1], busy[1]}), 0);
        chk("rst_rdata0", 64'(m0_rdata[1]), 0);
        chk("rst_rdata1", 64'(m1_rdata[1]), 0);
        chk("rst_mem_ad", 64'(mem_ad[1]), 0);
        chk("rst_mem_din", 64'(mem_din[1]), 0);
        @(posedge clk);
        #1;
        drive(1, 1, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_m0_gnt", 64'(m0_gnt[1]), 1);
        exp_q[2].push_back('{cyc: cyc + 4, data: 32'hC0DE_0005});
        last_rd[2] = 32'hC0DE_0005;
        @(posedge clk);
        #1;
        drive(1, 0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("rel_mem_ce", 64'(mem_ce[1]), 1);
        chk("rel_mem_ad", 64'(mem_ad[1]), 64'h005);
        settle(6);

        // Port 0 write then read back
        issue(1, 0, 1'b1, 10'h010, 32'hDEAD_BEEF, '0, 1'b0, g);
        issue(1, 0, 1'b0, 10'h010, '0, 32'hDEAD_BEEF, 1'b0, g);
        settle(6);

        // Contention, both held for four accesses
        do_reset();
        drive(1, 0, 1'b1, 1'b1, 10'h020, 32'h0000_0A0A);
        drive(1, 1, 1'b1, 1'b1, 10'h030, 32'h0000_0B0B);
        n = 0;
        g_prev = 0;
        for (int i = 0; i < 20 && n < 4; i++) begin
            @(negedge clk);
            if (m0_gnt[1] || m1_gnt[1]) begin
                wins = m1_gnt[1] ? 1 : 0;
                chk($sformatf("contention_winner_%0d", n), 64'(wins), 64'(exp_win[n]));
                if (n > 0) chk("contention_spacing", 64'(cyc - g_prev), 2);
                g_prev = cyc;
                exp_q[2 + wins].push_back('{cyc: cyc + 2, data: '0});
                n++;
            end
            @(posedge clk);
            #1;
        end
        drive(1, 0, 1'b0, 1'b0, '0, '0);
        drive(1, 1, 1'b0, 1'b0, '0, '0);
        chk("contention_grants", 64'(n), 4);
        settle(6);

        // Read latency sweep across instances
        for (int k = 0; k < NI; k++) begin
            o0 = oce_cnt[k];
            issue(k, 0, 1'b0, 10'(12'h040 + k), '0, 32'hC0DE_0040 + 32'(k), 1'b0, g);
            settle(lat_of(k) + 2);
            chk($sformatf("oce_cycles_i%0d", k), 64'(oce_cnt[k] - o0), 64'(lat_of(k) + 1));
        end

        // Reset during WAIT abandons the read
        issue(1, 0, 1'b0, 10'h010, '0, 32'hDEAD_BEEF, 1'b0, g);
        chk("midrd_busy", 64'(busy[1]), 1);
        rst_n = 1'b0;
        flush();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrd_no_ack", 64'(m0_ack[1]), 0);
            chk("midrd_rdata", 64'(m0_rdata[1]), 0);
        end
        @(posedge clk);
        #1;
        issue(1, 0, 1'b0, 10'h010, '0, 32'hDEAD_BEEF, 1'b0, g);
        settle(6);

        // Back-to-back writes from port 1 with req held
        issue(1, 1, 1'b1, 10'h3FF, 32'h1111_0001, '0, 1'b1, g_prev);
        issue(1, 1, 1'b1, 10'h000, 32'h1111_0002, '0, 1'b1, g);
        chk("b2b_spacing_1", 64'(g - g_prev), 2);
        g_prev = g;
        issue(1, 1, 1'b1, 10'h001, 32'h1111_0003, '0, 1'b0, g);
        chk("b2b_spacing_2", 64'(g - g_prev), 2);
        settle(6);
        chk("b2b_m1_rdata_unchanged", 64'(m1_rdata[1]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port block RAM between two requesters: port 0 is the core's memory path (instruction fetch and data access through the multicycle controller); port 1 is the program loader/debug path.
- Sequences the RAM's ce/oce/wre controls for each access and handles the configurable read pipeline latency.
- Returns a single acknowledge pulse per access.
- Sits between the requesters and the RAM macro.

Parameters:
- ADDR_W, 10, word address width of the RAM.
- DATA_W, 32, data width.
- RD_LAT, 2, RAM read latency in cycles after the address-sampling edge (1 = bypass, 2 = output-register pipeline). Legal range 1..4.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  port 0 access request; held with its fields until m0_gnt.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  ADDR_W  port 0 address.
- m0_wdata  in  DATA_W  port 0 write data.
- m0_gnt  out  1  port 0 request accepted; 1-cycle pulse.
- m0_ack  out  1  port 0 access complete; 1-cycle pulse.
- m0_rdata  out  DATA_W  port 0 read data; valid while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_ack, m1_rdata: same as port 0, for port 1.
- mem_ce  out  1  RAM clock enable.
- mem_oce  out  1  RAM output-register enable.
- mem_wre  out  1  RAM write enable.
- mem_ad  out  ADDR_W  RAM address.
- mem_din  out  DATA_W  RAM write data.
- mem_dout  in  DATA_W  RAM read data.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including rdata registers, mem_ad and mem_din.
  - Latched request fields are cleared.
  - Any in-flight access is abandoned and no ack is issued for it.
- FSM states: IDLE, ACCESS, WAIT.
- IDLE:
  - If any req is high, the winner's gnt is asserted combinationally in that same cycle.
  - At the edge: winner id, we, addr and wdata are latched, and the FSM moves to ACCESS.
  - With no req, the FSM stays in IDLE.
- Arbitration (default): fixed priority, port 0 wins when both ports request.
- ACCESS (exactly 1 cycle):
  - mem_ce=1, mem_ad=latched addr, mem_din=latched wdata, mem_wre=latched we.
  - mem_oce=1 on reads, 0 on writes.
  - Write: next state IDLE; the winner's ack is a registered pulse in the following cycle.
  - Read: next state WAIT; the latency counter is loaded with RD_LAT.
- WAIT:
  - mem_oce=1, mem_ce=0, mem_ad held.
  - The counter decrements each cycle.
  - In the cycle where the count is 1, mem_dout is captured into the winner's rdata register at the edge, and the FSM moves to IDLE.
  - The winner's ack is asserted in the next cycle.
- Timing (req in cycle T0, IDLE, no contention):
  - Write ack at T2.
  - Read ack at T2+RD_LAT (RD_LAT=1 gives T3, RD_LAT=2 gives T4).
- Back-to-back accesses:
  - An ack cycle is an IDLE cycle, so a new gnt can coincide with an ack.
  - Sustained rate: one write per 2 cycles, one read per RD_LAT+2 cycles.
- Request handling:
  - req held high after gnt is treated as a new request.
  - A requester that drops req before gnt is never granted, and no error is raised.
  - Requests arriving while busy are not granted until IDLE.
- Data holding:
  - mX_rdata holds its last read value until that port's next read ack.
  - Writes do not change mX_rdata.
- Only the winning port's rdata, ack and gnt ever change for a given access.
- mem_we/mem_ce are never asserted outside ACCESS; mem_oce is never asserted in IDLE.

Optional Feature:
- Macro: MEM_PORT_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - A last-winner flag (reset value = port 1) is updated at every grant.
  - When both ports request in IDLE, the port not granted last wins.
  - A single requester is always granted.
- Not defined:
  - Fixed priority, port 0 always wins.
  - The last-winner flag does not exist.

Test Plan:
- Reset values: rst_n=0 with both ports requesting → all outputs 0, busy=0. Release reset with m0_req=1, we=0, addr=0x005 → m0_gnt at the first cycle, mem_ce=1 and mem_ad=0x005 at the next cycle.
- Port 0 write then read (RD_LAT=2): write addr=0x010, wdata=0xDEADBEEF → m0_ack 2 cycles after gnt. Then read addr=0x010 → m0_ack with m0_rdata=0xDEADBEEF 4 cycles after its req. m1_ack stays 0 throughout.
- Contention: m0_req and m1_req asserted together and held for 4 accesses.
  - Default build: m0 granted every time, m1 starved.
  - With MEM_PORT_ARBITER_ROUND_ROBIN_EN: grants alternate m0, m1, m0, m1.
- Latency sweep: RD_LAT=1, 2 and 4 with a memory model of matching latency → read ack at T2+RD_LAT. mem_oce high in exactly RD_LAT+1 cycles per read.
- Reset mid-read: assert rst_n=0 during WAIT → no ack afterward, rdata=0. The next request after release completes normally.
- Back-to-back: m1 issues 3 writes to 0x3FF, 0x000, 0x001 with req held continuously → gnt pulses 2 cycles apart, each coinciding with the previous ack. Address wrap values appear on mem_ad unchanged.
